note_judge_engine: RTL and testbench

//  Parametrised hit-judge/scoring engine for the guitar-game datapath. Takes note events from

---
 rtl/note_judge_engine.sv | 110 +++++++++++
 tb/tb_note_judge_engine.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/note_judge_engine.sv
// note_judge_engine: timed hit-window judge with saturating score/combo and lane LEDs.
// Define COMBO_MULT_EN to scale hit points by a combo-dependent multiplier (x1..x4).
module note_judge_engine #(
    parameter int LANES   = 5,
    parameter int WINDOW  = 8,
    parameter int SCORE_W = 8,
    parameter int COMBO_W = 6,
    parameter int HIT_PTS = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               note_valid,
    input  logic [LANES-1:0]   note_lanes,
    input  logic [LANES-1:0]   btn,
    output logic [LANES-1:0]   lane_led,
    output logic               hit,
    output logic               miss,
    output logic               busy,
    output logic               overrun,
    output logic [SCORE_W-1:0] score,
    output logic [COMBO_W-1:0] combo
);
    localparam int WW = $clog2(WINDOW + 1);
    localparam int PW = SCORE_W + 3;
    typedef enum logic [1:0] {IDLE, ARMED, HIT, MISS} state_t;
    state_t             state_q, state_d;
    logic [LANES-1:0]   target_q, target_d, pressed_q, pressed_d, btn_prev_q, rise;
    logic [WW-1:0]      win_q, win_d;
    logic [SCORE_W-1:0] score_q, score_d, score_sat;
    logic [COMBO_W-1:0] combo_q, combo_d;
    logic               overrun_q, overrun_d;
    logic [PW-1:0]      pts;
    logic [PW:0]        sum;
    assign rise = btn & ~btn_prev_q;
`ifdef COMBO_MULT_EN
    logic [COMBO_W-1:0] grp;
    logic [2:0]         mult;
    assign grp  = combo_q >> 3;
    assign mult = (grp > COMBO_W'(2)) ? 3'd4 : 3'(grp) + 3'd1;
    assign pts  = PW'(HIT_PTS) * PW'(mult);
`else
    assign pts = PW'(HIT_PTS);
`endif
    assign sum       = (PW + 1)'(score_q) + (PW + 1)'(pts);
    assign score_sat = (sum > (PW + 1)'({SCORE_W{1'b1}})) ? '1 : sum[SCORE_W-1:0];
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        pressed_d = pressed_q;
        win_d     = win_q;
        score_d   = score_q;
        combo_d   = combo_q;
        overrun_d = overrun_q | (note_valid & (state_q != IDLE));
        case (state_q)
            IDLE: if (note_valid && |note_lanes) begin
                state_d   = ARMED;
                target_d  = note_lanes;
                pressed_d = '0;
                win_d     = WW'(WINDOW);
            end
            ARMED: begin
                pressed_d = pressed_q | (rise & target_q);
                win_d     = tick ? win_q - WW'(1) : win_q;
                // wrong lane beats completion, completion beats expiry
                if (|(rise & ~target_q))
                    state_d = MISS;
                else if (pressed_d == target_q)
                    state_d = HIT;
                else if (tick && win_q == WW'(1))
                    state_d = MISS;
            end
            default: state_d = IDLE;
        endcase
        if (state_q == ARMED && state_d == HIT) begin
            score_d = score_sat;
            combo_d = &combo_q ? combo_q : combo_q + COMBO_W'(1);
        end
        if (state_q == ARMED && state_d == MISS)
            combo_d = '0;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            target_q   <= '0;
            pressed_q  <= '0;
            btn_prev_q <= '0;
            win_q      <= '0;
            score_q    <= '0;
            combo_q    <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            pressed_q  <= pressed_d;
            btn_prev_q <= btn;
            win_q      <= win_d;
            score_q    <= score_d;
            combo_q    <= combo_d;
            overrun_q  <= overrun_d;
        end
    end
    assign lane_led = (state_q == ARMED) ? target_q : '0;
    assign hit      = (state_q == HIT);
    assign miss     = (state_q == MISS);
    assign busy     = (state_q != IDLE);
    assign overrun  = overrun_q;
    assign score    = score_q;
    assign combo    = combo_q;
endmodule

// File: tb/tb_note_judge_engine.sv
// tb_note_judge_engine: directed and randomized checks against a note-level reference model.
module tb_note_judge_engine;
    localparam int LANES = 5, WINDOW = 8, SCORE_W = 8, COMBO_W = 6, HIT_PTS = 1;
    logic clk = 0, rst = 0, tick = 0, note_valid = 0;
    logic [LANES-1:0] note_lanes = 0, btn = 0, lane_led;
    logic hit, miss, busy, overrun;
    logic [SCORE_W-1:0] score;
    logic [COMBO_W-1:0] combo;
    int tests = 0, fails = 0;
    // model: phase 0 = waiting for a note, 1 = note live, 2 = verdict cycle
    int m_phase, m_ticks, m_score, m_combo;
    bit m_hit, m_over;
    logic [LANES-1:0] m_target, m_need, m_prev;

    note_judge_engine #(.LANES(LANES), .WINDOW(WINDOW), .SCORE_W(SCORE_W),
                        .COMBO_W(COMBO_W), .HIT_PTS(HIT_PTS)) dut (
        .clk(clk), .rst(rst), .tick(tick), .note_valid(note_valid),
        .note_lanes(note_lanes), .btn(btn), .lane_led(lane_led), .hit(hit),
        .miss(miss), .busy(busy), .overrun(overrun), .score(score), .combo(combo));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_ticks = 0; m_score = 0; m_combo = 0;
        m_hit = 0; m_over = 0; m_target = 0; m_need = 0; m_prev = 0;
    endtask

    task automatic judge(input bit h);
        int pts, mult;
        m_phase = 2;
        m_hit = h;
        if (h) begin
`ifdef COMBO_MULT_EN
            mult = 1 + m_combo / 8;
            if (mult > 4) mult = 4;
            pts = HIT_PTS * mult;
`else
            pts = HIT_PTS;
`endif
            m_score = (m_score + pts > 255) ? 255 : m_score + pts;
            m_combo = (m_combo + 1 > 63) ? 63 : m_combo + 1;
        end else
            m_combo = 0;
    endtask

    task automatic model_step();
        logic [LANES-1:0] rise;
        int ph;
        rise = btn & ~m_prev;
        ph = m_phase;
        if (note_valid && ph != 0) m_over = 1;
        if (ph == 2)
            m_phase = 0;
        else if (ph == 0) begin
            if (note_valid && note_lanes != 0) begin
                m_phase = 1; m_target = note_lanes; m_need = note_lanes; m_ticks = WINDOW;
            end
        end else begin
            m_need &= ~rise;
            if ((rise & ~m_target) != 0) judge(0);
            else if (m_need == 0) judge(1);
            else if (tick) begin
                m_ticks--;
                if (m_ticks == 0) judge(0);
            end
        end
        m_prev = btn;
    endtask

    task automatic compare();
        chk("lane_led", lane_led, m_phase == 1 ? m_target : 0);
        chk("hit", hit, m_phase == 2 && m_hit);
        chk("miss", miss, m_phase == 2 && !m_hit);
        chk("busy", busy, m_phase != 0);
        chk("overrun", overrun, m_over);
        chk("score", score, m_score);
        chk("combo", combo, m_combo);
    endtask

    task automatic cycle(input bit t, input bit nv, input logic [LANES-1:0] nl, input logic [LANES-1:0] b);
        tick = t; note_valid = nv; note_lanes = nl; btn = b;
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic one_hit();
        cycle(0, 1, 5'b00001, 0);
        cycle(0, 0, 0, 5'b00001);
        cycle(0, 0, 0, 0);
    endtask

    task automatic do_reset();
        tick = 0; note_valid = 0; note_lanes = 0; btn = 0;
        rst = 0;
        model_reset();
        @(negedge clk);
        rst = 1;
    endtask

    initial begin
        int r;
        logic [LANES-1:0] b;
        model_reset();
        repeat (2) @(negedge clk);
        compare();
        rst = 1;
        // single lane hit after three ticks
        cycle(0, 1, 5'b00100, 0);
        chk("t1_led_armed", lane_led, 5'b00100);
        repeat (3) cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 5'b00100);
        chk("t1_hit", hit, 1);
        chk("t1_score", score, 1);
        chk("t1_combo", combo, 1);
        chk("t1_led_off", lane_led, 0);
        cycle(0, 0, 0, 5'b00100);
        chk("t1_hit_one_cycle", hit, 0);
        // chord completed over several cycles
        cycle(0, 1, 5'b10001, 0);
        cycle(0, 0, 0, 5'b00001);
        cycle(1, 0, 0, 5'b00001);
        cycle(1, 0, 0, 5'b00001);
        cycle(0, 0, 0, 5'b10001);
        chk("t2_hit", hit, 1);
        chk("t2_score", score, 2);
        chk("t2_combo", combo, 2);
        cycle(0, 0, 0, 0);
        // expiry
        cycle(0, 1, 5'b01000, 0);
        repeat (7) cycle(1, 0, 0, 0);
        chk("t3_no_early_miss", miss, 0);
        cycle(1, 0, 0, 0);
        chk("t3_miss", miss, 1);
        chk("t3_combo", combo, 0);
        chk("t3_score", score, 2);
        cycle(0, 0, 0, 0);
        // wrong lane, then wrong lane plus completion
        cycle(0, 1, 5'b00010, 0);
        cycle(0, 0, 0, 5'b01000);
        chk("t4_wrong_miss", miss, 1);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 5'b00010, 0);
        cycle(0, 0, 0, 5'b01010);
        chk("t4_wrong_plus_done_miss", miss, 1);
        chk("t4_wrong_plus_done_hit", hit, 0);
        cycle(0, 0, 0, 0);
        // button held across arming does not count
        cycle(0, 0, 0, 5'b00100);
        cycle(0, 1, 5'b00100, 5'b00100);
        cycle(0, 0, 0, 5'b00100);
        chk("held_no_hit", hit, 0);
        chk("held_busy", busy, 1);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 5'b00100);
        chk("held_then_new_edge_hit", hit, 1);
        chk("held_score", score, 3);
        cycle(0, 0, 0, 0);
        // note while busy, then asynchronous reset mid-ARMED
        chk("ovr_clear", overrun, 0);
        cycle(0, 1, 5'b00001, 0);
        cycle(0, 1, 5'b00010, 0);
        chk("ovr_set", overrun, 1);
        chk("ovr_target_kept", lane_led, 5'b00001);
        rst = 0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_led", lane_led, 0);
        chk("arst_score", score, 0);
        chk("arst_overrun", overrun, 0);
        model_reset();
        @(negedge clk);
        rst = 1;
        // 16 hits then one more at combo 16
        repeat (16) one_hit();
        cycle(0, 1, 5'b00001, 0);
        cycle(0, 0, 0, 5'b00001);
`ifdef COMBO_MULT_EN
        chk("mult_score_at_combo16", score, 27);
`else
        chk("mult_score_at_combo16", score, 17);
`endif
        cycle(0, 0, 0, 0);
        // saturation
        do_reset();
        repeat (260) one_hit();
        chk("sat_score", score, 255);
        chk("sat_combo", combo, 63);
        // randomized traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 9);
            b = (r < 6) ? (m_target & LANES'($urandom)) : (r == 6) ? LANES'($urandom) : btn;
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                  ($urandom_range(0, 3) == 0) ? '0 : LANES'($urandom), b);
            if (i % 1000 == 999) do_reset();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
